pbit_update_scheduler: RTL and testbench

- Parametrised sequential update-order scheduler for a network of N_PBITS p-bits partitioned into up to N_GROUPS update groups.
- Steps through groups in order. Each step fires a one-cycle enable to every p-bit in the current group's mask, then waits a programmable settle time.
- Counts full sweeps and stops after a programmed count, or runs freely.
- Group membership is held in a run-time writable mask table, so ordering and grouping change without re-synthesis.
- Sits between the p-bit array (drives each p-bit's update enable) and the host/control logic.

---
 rtl/pbit_update_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_pbit_update_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pbit_update_scheduler.sv
// Sequential update-order scheduler for a p-bit network: walks a run-time writable
// group mask table, fires one-cycle update enables per group, then settles.
module pbit_update_scheduler #(
   parameter int N_PBITS  = 3,
   parameter int N_GROUPS = 3,
   parameter int DWELL_W  = 8,
   parameter int SWEEP_W  = 16,
   parameter int GI_W     = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
   parameter int NG_W     = $clog2(N_GROUPS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [DWELL_W-1:0] dwell_cycles,
   input  logic [SWEEP_W-1:0] num_sweeps,
   input  logic [NG_W-1:0]    n_groups_active,
   input  logic               mask_wr_en,
   input  logic [GI_W-1:0]    mask_wr_idx,
   input  logic [N_PBITS-1:0] mask_wr_data,
   output logic [N_PBITS-1:0] pbit_en,
   output logic [GI_W-1:0]    group_idx,
   output logic [SWEEP_W-1:0] sweep_cnt,
   output logic               busy,
   output logic               sweep_done,
   output logic               done
);

   typedef enum logic [1:0] {IDLE, FIRE, SETTLE} state_t;

   state_t                              state_reg;
   logic [GI_W-1:0]                     grp_reg;
   logic [GI_W-1:0]                     last_reg;
   logic [DWELL_W-1:0]                  dwell_reg;
   logic [DWELL_W-1:0]                  cnt_reg;
   logic [SWEEP_W-1:0]                  nsw_reg;
   logic [SWEEP_W-1:0]                  sweep_cnt_reg;
   logic [N_PBITS-1:0]                  pbit_en_reg;
   logic                                sweep_done_reg;
   logic                                done_reg;
   logic                                busy_reg;

   logic [N_GROUPS-1:0][N_PBITS-1:0]    mask_reg;
   logic [N_GROUPS-1:0][N_PBITS-1:0]    mask_dflt;

   logic [GI_W-1:0]                     start_last;
   logic [SWEEP_W-1:0]                  sweep_cnt_inc;
   logic [SWEEP_W-1:0]                  cnt_after;
   logic                                hit;
   logic                                slot_end;
   logic [GI_W-1:0]                     next_grp;
   logic                                next_is_last;

   // Default table: group g drives p-bit g alone; surplus groups are empty.
   genvar gi;
   generate
      for (gi = 0; gi < N_GROUPS; gi++) begin : g_dflt
         if (gi < N_PBITS) begin : g_onehot
            assign mask_dflt[gi] = N_PBITS'(1) << gi;
         end else begin : g_empty
            assign mask_dflt[gi] = '0;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_reg <= mask_dflt;
      end else if (mask_wr_en && ({1'b0, mask_wr_idx} < (GI_W + 1)'(N_GROUPS))) begin
         mask_reg[mask_wr_idx] <= mask_wr_data;
      end
   end

   always_comb begin
      start_last = GI_W'(N_GROUPS - 1);
      if ((n_groups_active != '0) && (int'(n_groups_active) <= N_GROUPS)) begin
         start_last = GI_W'(n_groups_active - 1'b1);
      end
   end

   // cnt_after is the completed-sweep count visible in the cycle being scheduled,
   // so done lands on the sweep whose completion reaches num_sweeps.
   always_comb begin
      sweep_cnt_inc = (&sweep_cnt_reg) ? sweep_cnt_reg : sweep_cnt_reg + 1'b1;
      cnt_after     = sweep_done_reg ? sweep_cnt_inc : sweep_cnt_reg;
      hit           = (nsw_reg != '0) && (({1'b0, cnt_after} + 1'b1) == {1'b0, nsw_reg});
      slot_end      = ((state_reg == FIRE) && (dwell_reg == '0)) ||
                      ((state_reg == SETTLE) && (cnt_reg == DWELL_W'(1)));
      next_grp      = (grp_reg == last_reg) ? '0 : grp_reg + 1'b1;
      next_is_last  = (next_grp == last_reg);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         grp_reg        <= '0;
         last_reg       <= '0;
         dwell_reg      <= '0;
         cnt_reg        <= '0;
         nsw_reg        <= '0;
         sweep_cnt_reg  <= '0;
         pbit_en_reg    <= '0;
         sweep_done_reg <= 1'b0;
         done_reg       <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         pbit_en_reg    <= '0;
         sweep_done_reg <= 1'b0;
         done_reg       <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start && !stop) begin
                  dwell_reg     <= dwell_cycles;
                  nsw_reg       <= num_sweeps;
                  last_reg      <= start_last;
                  grp_reg       <= '0;
                  sweep_cnt_reg <= '0;
                  busy_reg      <= 1'b1;
                  state_reg     <= FIRE;
                  pbit_en_reg   <= mask_reg[0];
                  if ((dwell_cycles == '0) && (start_last == '0)) begin
                     sweep_done_reg <= 1'b1;
                     done_reg       <= (num_sweeps == SWEEP_W'(1));
                  end
               end
            end
            FIRE, SETTLE: begin
               if (stop) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  if (sweep_done_reg) begin
                     sweep_cnt_reg <= sweep_cnt_inc;
                  end
                  if (slot_end) begin
                     if (done_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                     end else begin
                        grp_reg     <= next_grp;
                        state_reg   <= FIRE;
                        pbit_en_reg <= mask_reg[next_grp];
                        if (next_is_last && (dwell_reg == '0)) begin
                           sweep_done_reg <= 1'b1;
                           done_reg       <= hit;
                        end
                     end
                  end else if (state_reg == FIRE) begin
                     state_reg <= SETTLE;
                     cnt_reg   <= dwell_reg;
                     if ((dwell_reg == DWELL_W'(1)) && (grp_reg == last_reg)) begin
                        sweep_done_reg <= 1'b1;
                        done_reg       <= hit;
                     end
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                     // Entering the final settle cycle of the last group.
                     if ((cnt_reg == DWELL_W'(2)) && (grp_reg == last_reg)) begin
                        sweep_done_reg <= 1'b1;
                        done_reg       <= hit;
                     end
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign pbit_en    = pbit_en_reg;
   assign group_idx  = grp_reg;
   assign sweep_cnt  = sweep_cnt_reg;
   assign busy       = busy_reg;
   assign sweep_done = sweep_done_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_pbit_update_scheduler.sv
// Directed bench for pbit_update_scheduler: per-cycle enable/pulse vectors per scenario.
module tb_pbit_update_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic [7:0]  dwell_cycles;
   logic [15:0] num_sweeps;
   logic [1:0]  n_groups_active;
   logic        mask_wr_en;
   logic [1:0]  mask_wr_idx;
   logic [2:0]  mask_wr_data;
   logic [2:0]  pbit_en;
   logic [1:0]  group_idx;
   logic [15:0] sweep_cnt;
   logic        busy;
   logic        sweep_done;
   logic        done;

   int errors = 0;
   int checks = 0;

   logic [2:0] exp_en [$];
   bit         exp_sd [$];
   bit         exp_dn [$];
   int         wr_at   = -1;
   logic [1:0] wr_idx_v;
   logic [2:0] wr_data_v;
   int         stop_at = -1;

   always #5 clk = ~clk;

   pbit_update_scheduler #(
      .N_PBITS(3), .N_GROUPS(3), .DWELL_W(8), .SWEEP_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .dwell_cycles(dwell_cycles), .num_sweeps(num_sweeps),
      .n_groups_active(n_groups_active), .mask_wr_en(mask_wr_en),
      .mask_wr_idx(mask_wr_idx), .mask_wr_data(mask_wr_data),
      .pbit_en(pbit_en), .group_idx(group_idx), .sweep_cnt(sweep_cnt),
      .busy(busy), .sweep_done(sweep_done), .done(done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write_mask(input logic [1:0] idx, input logic [2:0] data);
      mask_wr_en   = 1'b1;
      mask_wr_idx  = idx;
      mask_wr_data = data;
      tick();
      mask_wr_en   = 1'b0;
      $display("mask write idx=%0d data=%b", idx, data);
   endtask

   // Pulses start, then checks exp_* for each cycle following the start edge.
   task automatic run_seq(input string name, input logic [7:0] dw, input logic [15:0] ns,
                          input logic [1:0] nga, input int n_cyc,
                          input bit chk_after, input logic [15:0] exp_cnt);
      dwell_cycles    = dw;
      num_sweeps      = ns;
      n_groups_active = nga;
      start           = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < n_cyc; k++) begin
         if (k == wr_at) begin
            mask_wr_en   = 1'b1;
            mask_wr_idx  = wr_idx_v;
            mask_wr_data = wr_data_v;
         end else begin
            mask_wr_en = 1'b0;
         end
         stop = (k == stop_at);
         checks++;
         if (pbit_en !== exp_en[k]) begin
            errors++;
            $display("FAIL %s cyc%0d pbit_en got %b want %b", name, k, pbit_en, exp_en[k]);
         end
         checks++;
         if (sweep_done !== exp_sd[k]) begin
            errors++;
            $display("FAIL %s cyc%0d sweep_done got %b want %b", name, k, sweep_done, exp_sd[k]);
         end
         checks++;
         if (done !== exp_dn[k]) begin
            errors++;
            $display("FAIL %s cyc%0d done got %b want %b", name, k, done, exp_dn[k]);
         end
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s cyc%0d busy got %b want 1", name, k, busy);
         end
         tick();
      end
      mask_wr_en = 1'b0;
      stop       = 1'b0;
      if (chk_after) begin
         checks++;
         if (busy !== 1'b0 || pbit_en !== 3'b000 || done !== 1'b0 || sweep_done !== 1'b0) begin
            errors++;
            $display("FAIL %s end busy/pbit_en/done/sweep_done got %b/%b/%b/%b want 0/000/0/0",
                     name, busy, pbit_en, done, sweep_done);
         end
         checks++;
         if (sweep_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s end sweep_cnt got %0d want %0d", name, sweep_cnt, exp_cnt);
         end
      end
      $display("run %s: dwell=%0d sweeps=%0d groups=%0d cycles=%0d sweep_cnt=%0d",
               name, dw, ns, nga, n_cyc, sweep_cnt);
      wr_at   = -1;
      stop_at = -1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; dwell_cycles = '0; num_sweeps = '0;
      n_groups_active = '0; mask_wr_en = 1'b0; mask_wr_idx = '0; mask_wr_data = '0;
      tick();
      tick();
      checks++;
      if (pbit_en !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || sweep_done !== 1'b0 ||
          group_idx !== 2'd0 || sweep_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset outputs got en=%b busy=%b done=%b sd=%b grp=%0d cnt=%0d want all 0",
                  pbit_en, busy, done, sweep_done, group_idx, sweep_cnt);
      end
      #3 rst_n = 1'b1;
      tick();
      $display("reset released");
   endtask

   task automatic test_two_sweeps;
      exp_en = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      exp_sd = '{0, 0, 1, 0, 0, 1};
      exp_dn = '{0, 0, 0, 0, 0, 1};
      run_seq("two_sweeps", 8'd0, 16'd2, 2'd3, 6, 1'b1, 16'd2);
   endtask

   task automatic test_dwell;
      exp_en = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000};
      exp_sd = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
      exp_dn = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
      run_seq("dwell2", 8'd2, 16'd1, 2'd3, 9, 1'b1, 16'd1);
   endtask

   task automatic test_mask_race;
      wr_at     = 0;
      wr_idx_v  = 2'd1;
      wr_data_v = 3'b101;
      exp_en = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b101, 3'b100};
      exp_sd = '{0, 0, 1, 0, 0, 1};
      exp_dn = '{0, 0, 0, 0, 0, 1};
      run_seq("mask_race", 8'd0, 16'd2, 2'd3, 6, 1'b1, 16'd2);
      write_mask(2'd3, 3'b111);
      exp_en = '{3'b001, 3'b101, 3'b100};
      exp_sd = '{0, 0, 1};
      exp_dn = '{0, 0, 1};
      run_seq("idx_oob", 8'd0, 16'd1, 2'd3, 3, 1'b1, 16'd1);
   endtask

   task automatic test_groups;
      write_mask(2'd0, 3'b011);
      write_mask(2'd1, 3'b100);
      exp_en = '{3'b011, 3'b100, 3'b011, 3'b100, 3'b011, 3'b100};
      exp_sd = '{0, 1, 0, 1, 0, 1};
      exp_dn = '{0, 0, 0, 0, 0, 1};
      run_seq("two_groups", 8'd0, 16'd3, 2'd2, 6, 1'b1, 16'd3);
      exp_en = '{3'b011, 3'b100, 3'b100};
      exp_sd = '{0, 0, 1};
      exp_dn = '{0, 0, 1};
      run_seq("nga_zero", 8'd0, 16'd1, 2'd0, 3, 1'b1, 16'd1);
   endtask

   task automatic test_free_run;
      stop_at = 6;
      exp_en = '{3'b011, 3'b100, 3'b100, 3'b011, 3'b100, 3'b100, 3'b011};
      exp_sd = '{0, 0, 1, 0, 0, 1, 0};
      exp_dn = '{0, 0, 0, 0, 0, 0, 0};
      run_seq("free_run_stop", 8'd0, 16'd0, 2'd3, 7, 1'b1, 16'd2);
   endtask

   task automatic test_reset_mid_run;
      exp_en = '{3'b011, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000};
      exp_sd = '{0, 0, 0, 0, 0, 0};
      exp_dn = '{0, 0, 0, 0, 0, 0};
      run_seq("pre_reset", 8'd3, 16'd0, 2'd3, 6, 1'b0, 16'd0);
      checks++;
      if (group_idx !== 2'd1) begin
         errors++;
         $display("FAIL mid_settle group_idx got %0d want 1", group_idx);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || group_idx !== 2'd0 || pbit_en !== 3'b000 || sweep_cnt !== 16'd0) begin
         errors++;
         $display("FAIL async_reset got busy=%b grp=%0d en=%b cnt=%0d want 0/0/000/0",
                  busy, group_idx, pbit_en, sweep_cnt);
      end
      #3 rst_n = 1'b1;
      tick();
      exp_en = '{3'b001, 3'b010, 3'b100};
      exp_sd = '{0, 0, 1};
      exp_dn = '{0, 0, 1};
      run_seq("masks_restored", 8'd0, 16'd1, 2'd3, 3, 1'b1, 16'd1);
   endtask

   task automatic test_start_stop;
      dwell_cycles = 8'd0; num_sweeps = 16'd1; n_groups_active = 2'd3;
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      checks++;
      if (busy !== 1'b0 || pbit_en !== 3'b000) begin
         errors++;
         $display("FAIL start_stop got busy=%b en=%b want 0/000", busy, pbit_en);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start_stop_hold busy got %b want 0", busy);
      end
      $display("start+stop together: busy=%b", busy);
   endtask

   initial begin
      test_reset();
      test_two_sweeps();
      test_dwell();
      test_mask_race();
      test_groups();
      test_free_run();
      test_reset_mid_run();
      test_start_stop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
